// File: rtl/int_to_floating_point.sv
// Multi-cycle signed-integer to IEEE-754 converter with selectable rounding and an inexact flag.
// Define INT_TO_FLOAT_FAST_NORM_EN for a single-cycle NORM (LZC + barrel shift); default is bit-serial NORM.
module int_to_floating_point #(
  parameter int int_size      = 64,
  parameter int mantissa_size = 23,
  parameter int exponent_size = 8,
  parameter int precision     = 32,
  parameter int exp_bias      = 127
) (
  input  logic                 clk,
  input  logic                 reset,
  // The operand port cannot be called "int" (reserved word), hence int_value.
  input  logic [int_size-1:0]  int_value,
  input  logic [1:0]           conv,
  input  logic                 valid_in,
  output logic                 ready,
  output logic [precision-1:0] float,
  output logic                 inexact_flag,
  output logic                 valid_out,
  output logic [1:0]           fsm_state
);

  // Handshake: an operand is accepted on a rising edge where ready && valid_in;
  // valid_out is a one-cycle pulse and float/inexact_flag hold until the next result.

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int CW = $clog2(int_size) + 1;
  localparam int G  = int_size - 2 - mantissa_size;

  logic [1:0]               state;
  logic                     sign;
  logic [1:0]               mode;
  logic [int_size-1:0]      mag;
  logic [CW-1:0]            exp_cnt;

  logic [int_size-1:0]      abs_in;
  logic [mantissa_size-1:0] frac;
  logic                     guard;
  logic                     sticky;
  logic                     round_up;
  logic [mantissa_size:0]   frac_sum;
  logic [exponent_size-1:0] exp_field;

  assign ready     = (state == IDLE);
  assign valid_out = (state == DONE);
  assign fsm_state = state;

  // Two's-complement negate also maps the most negative value onto 2^(int_size-1) unsigned.
  assign abs_in = int_value[int_size-1] ? (~int_value + 1'b1) : int_value;

  assign frac   = mag[int_size-2 -: mantissa_size];
  assign guard  = mag[G];
  assign sticky = |mag[G-1:0];

  always_comb begin
    round_up = 1'b0;
    case (mode)
      2'b01:   round_up = (guard | sticky) & ~sign;
      2'b10:   round_up = (guard | sticky) & sign;
      2'b11:   round_up = guard & (sticky | frac[0]);
      default: round_up = 1'b0;
    endcase
  end

  // A carry out of frac leaves frac_sum's low bits zero and bumps the exponent.
  assign frac_sum  = {1'b0, frac} + {{mantissa_size{1'b0}}, round_up};
  assign exp_field = exponent_size'(exp_cnt) + exponent_size'(frac_sum[mantissa_size])
                   + exponent_size'(exp_bias);

`ifdef INT_TO_FLOAT_FAST_NORM_EN
  logic [CW-1:0] lz;

  // Highest set bit wins because later loop iterations overwrite earlier ones.
  always_comb begin
    lz = '0;
    for (int i = 0; i < int_size; i++) begin
      if (mag[i]) lz = CW'(int_size - 1 - i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sign         <= 1'b0;
      mode         <= 2'b00;
      mag          <= '0;
      exp_cnt      <= '0;
      float        <= '0;
      inexact_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            mode    <= conv;
            sign    <= int_value[int_size-1];
            mag     <= abs_in;
            exp_cnt <= CW'(int_size - 1);
            if (abs_in == '0) begin
              float        <= '0;
              inexact_flag <= 1'b0;
              state        <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
`ifdef INT_TO_FLOAT_FAST_NORM_EN
          mag     <= mag << lz;
          exp_cnt <= exp_cnt - lz;
          state   <= ROUND;
`else
          if (mag[int_size-1]) begin
            state <= ROUND;
          end else begin
            mag     <= mag << 1;
            exp_cnt <= exp_cnt - CW'(1);
          end
`endif
        end
        ROUND: begin
          float        <= {sign, exp_field, frac_sum[mantissa_size-1:0]};
          inexact_flag <= guard | sticky;
          state        <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
